// File: rtl/mux_sched_nto1.sv
// N:1 valid/ready channel multiplexer with manual or round-robin selection
// and a single-entry registered output stage.
module mux_sched_nto1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch,
    output logic [N-1:0]   grant
);

    logic [SW-1:0] ptr_r;
    logic [SW-1:0] ptr_nxt_s;
    logic [SW-1:0] cand_s;
    logic          cand_vld_s;
    logic          load_en_s;
    logic [N-1:0]  grant_s;
    logic [W-1:0]  cand_data_s;
    logic [W-1:0]  out_data_r;
    logic          out_valid_r;
    logic [SW-1:0] out_ch_r;
    int            scan_idx_s;

    assign load_en_s = ~out_valid_r | out_ready;

    // Pick the candidate channel: sel in manual mode, first valid from ptr in RR mode
    always_comb begin
        cand_vld_s = 1'b0;
        cand_s     = {SW{1'b0}};
        scan_idx_s = 0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                scan_idx_s = (int'(ptr_r) + i >= N) ? int'(ptr_r) + i - N : int'(ptr_r) + i;
                for (int k = 0; k < N; k++) begin
                    if (!cand_vld_s && (scan_idx_s == k) && in_valid[k]) begin
                        cand_vld_s = 1'b1;
                        cand_s     = SW'(k);
                    end else begin
                        cand_vld_s = cand_vld_s;
                    end
                end
            end
        end else begin
            // An out-of-range sel matches no k, so it can never grant
            for (int k = 0; k < N; k++) begin
                if ((sel == SW'(k)) && in_valid[k]) begin
                    cand_vld_s = 1'b1;
                    cand_s     = SW'(k);
                end else begin
                    cand_vld_s = cand_vld_s;
                end
            end
        end
    end

    // Decode candidate into the one-hot grant and select its data word
    always_comb begin
        grant_s     = {N{1'b0}};
        cand_data_s = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (cand_s == SW'(k)) begin
                cand_data_s = in_data[k*W +: W];
                grant_s[k]  = cand_vld_s & load_en_s & rst_n;
            end else begin
                grant_s[k]  = 1'b0;
            end
        end
    end

    assign ptr_nxt_s = (int'(cand_s) == N - 1) ? {SW{1'b0}} : cand_s + {{(SW-1){1'b0}}, 1'b1};

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_ch_r    <= {SW{1'b0}};
            ptr_r       <= {SW{1'b0}};
        end else if (|grant_s) begin
            out_data_r  <= cand_data_s;
            out_ch_r    <= cand_s;
            out_valid_r <= 1'b1;
            if (mode) begin
                ptr_r <= ptr_nxt_s;
            end
        end else if (out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    assign grant     = grant_s;
    assign in_ready  = grant_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_sched_nto1.sv
// Directed testbench for mux_sched_nto1: default 4x8 instance plus a 5-channel
// instance for the out-of-range select case.
module tb_mux_sched_nto1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [3:0]  grant;

    logic [39:0] in_data2;
    logic [4:0]  in_valid2;
    logic [4:0]  in_ready2;
    logic        mode2;
    logic [2:0]  sel2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [2:0]  out_ch2;
    logic [4:0]  grant2;

    logic [7:0]  chd [4];
    int          vectors;
    int          miscompares;

    mux_sched_nto1 #(.N(4), .W(8), .SW(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .grant(grant)
    );

    mux_sched_nto1 #(.N(5), .W(8), .SW(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .mode(mode2), .sel(sel2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2), .grant(grant2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        in_valid = 4'b1111;
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        vectors++; if (out_ch !== 2'd0) begin miscompares++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rst_grant: got %b want 0000", grant); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        in_valid = 4'b0000;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_manual;
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL man_grant: got %b want 0100", grant); end
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL man_in_ready: got %b want 0100", in_ready); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL man_out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL man_out_data: got %h want a5", out_data); end
        vectors++; if (out_ch !== 2'd2) begin miscompares++; $display("FAIL man_out_ch: got %0d want 2", out_ch); end
        in_valid = 4'b0000;
        #1;
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL man_ready_once: got %b want 0000", in_ready); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL man_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_manual_invalid;
        sel = 2'd2; in_valid = 4'b1011;
        #1;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL inv_grant: got %b want 0000", grant); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL inv_out_valid: got %b want 0", out_valid); end
        in_valid = 4'b0000;
        mode2 = 1'b0; sel2 = 3'd7; in_valid2 = 5'b11111; out_ready2 = 1'b1;
        repeat (3) begin
            #1;
            vectors++; if (grant2 !== 5'b00000) begin miscompares++; $display("FAIL oor_grant: got %b want 00000", grant2); end
            @(posedge clk); #1;
            vectors++; if (out_valid2 !== 1'b0) begin miscompares++; $display("FAIL oor_out_valid: got %b want 0", out_valid2); end
        end
        sel2 = 3'd4;
        #1;
        vectors++; if (grant2 !== 5'b10000) begin miscompares++; $display("FAIL top_grant: got %b want 10000", grant2); end
        @(posedge clk); #1;
        vectors++; if (out_valid2 !== 1'b1) begin miscompares++; $display("FAIL top_out_valid: got %b want 1", out_valid2); end
        vectors++; if (out_data2 !== 8'h54) begin miscompares++; $display("FAIL top_out_data: got %h want 54", out_data2); end
        vectors++; if (out_ch2 !== 3'd4) begin miscompares++; $display("FAIL top_out_ch: got %0d want 4", out_ch2); end
        in_valid2 = 5'b00000;
    endtask

    task automatic test_round_robin;
        int exp_all [5] = '{0, 1, 2, 3, 0};
        int exp_odd [4] = '{1, 3, 1, 3};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || out_ch !== 2'(exp_all[i])) begin
                miscompares++; $display("FAIL rr_all[%0d]: got ch %0d valid %b want ch %0d valid 1", i, out_ch, out_valid, exp_all[i]);
            end
            vectors++; if (out_data !== chd[exp_all[i]]) begin
                miscompares++; $display("FAIL rr_all_data[%0d]: got %h want %h", i, out_data, chd[exp_all[i]]);
            end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || out_ch !== 2'(exp_odd[i])) begin
                miscompares++; $display("FAIL rr_odd[%0d]: got ch %0d valid %b want ch %0d valid 1", i, out_ch, out_valid, exp_odd[i]);
            end
        end
        in_valid = 4'b0000;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin
            miscompares++; $display("FAIL bp_load: got valid %b data %h want 1 21", out_valid, out_data);
        end
        repeat (3) begin
            vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0000", in_ready); end
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1) begin
                miscompares++; $display("FAIL bp_hold: got valid %b data %h ch %0d want 1 21 1", out_valid, out_data, out_ch);
            end
        end
        sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_reload_ready: got %b want 1000", in_ready); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd3) begin
            miscompares++; $display("FAIL bp_no_bubble: got valid %b data %h ch %0d want 1 3c 3", out_valid, out_data, out_ch);
        end
        in_valid = 4'b0000;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_mode_switch;
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_ch !== 2'd2) begin miscompares++; $display("FAIL ms_rr_first: got %0d want 2", out_ch); end
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        #1;
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL ms_manual_grant: got %b want 0001", grant); end
        @(posedge clk); #1;
        vectors++; if (out_ch !== 2'd0 || out_data !== 8'h10) begin
            miscompares++; $display("FAIL ms_manual_out: got ch %0d data %h want 0 10", out_ch, out_data);
        end
        mode = 1'b1;
        #1;
        vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL ms_resume_grant: got %b want 1000", grant); end
        @(posedge clk); #1;
        vectors++; if (out_ch !== 2'd3 || out_data !== 8'h3C) begin
            miscompares++; $display("FAIL ms_resume_out: got ch %0d data %h want 3 3c", out_ch, out_data);
        end
        @(posedge clk); #1;
        vectors++; if (out_ch !== 2'd0) begin miscompares++; $display("FAIL ms_wrap: got %0d want 0", out_ch); end
        out_ready = 1'b0; in_valid = 4'b0000;
    endtask

    task automatic test_reset_midstream;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            miscompares++; $display("FAIL mid_async: got valid %b data %h ch %0d want 0 00 0", out_valid, out_data, out_ch);
        end
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL mid_grant: got %b want 0000", grant); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            miscompares++; $display("FAIL mid_ptr_reset: got valid %b ch %0d want 1 0", out_valid, out_ch);
        end
        @(posedge clk); #1;
        vectors++; if (out_ch !== 2'd1) begin miscompares++; $display("FAIL mid_ptr_next: got %0d want 1", out_ch); end
        in_valid = 4'b0000;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        chd[0] = 8'h10; chd[1] = 8'h21; chd[2] = 8'hA5; chd[3] = 8'h3C;
        rst_n = 1'b0;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        in_valid = 4'b0000; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_data2 = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
        in_valid2 = 5'b00000; mode2 = 1'b0; sel2 = 3'd0; out_ready2 = 1'b0;

        test_reset();
        test_manual();
        test_manual_invalid();
        test_round_robin();
        test_backpressure();
        test_mode_switch();
        test_reset_midstream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
